ddio_crc_link_top: RTL and testbench
====================================

// Module: ddio_crc_link_top
// PURPOSE
// - Self-contained CRC link demo for the DE10-Standard board.
// - TX side: on btn, builds DEPTH messages, appends a CRC-4 to each and stores them in a TX RAM.
// - On btn_SEND, streams the words over an internal word link (clkout strobe + dataout) to the RX side.
// - RX side re-checks each CRC, stores good words in an RX RAM, counts them and raises a sticky LED_alert on any mismatch.
// PARAMETERS
// - MESS_LEN  12        message bits
// - CRC_LEN   4         CRC bits
// - POLY      5'b10011  CRC generator x^4+x+1, MSB first
// - DEPTH     32        words per frame; address width 5
// - W = MESS_LEN+CRC_LEN+2 = 18; word = {valid, last, msg[11:0], crc[3:0]}
// PORTS
// - board_clk    in   1   sole clock, rising edge
// - rst          in   1   synchronous, active-high reset
// - btn          in   1   start generation; rising edge detected internally
// - btn_SEND     in   1   start transmission; rising edge detected internally
// - err_inject   in   1   level; while high, TX flips dataout[4] (msg LSB)
// - state_tx     out  3   TX FSM state
// - state_rx     out  3   RX FSM state
// - address_tx   out  5   TX RAM address
// - address_rx   out  5   RX RAM write address
// - wren_tx      out  1   TX RAM write strobe
// - clkout       out  1   one-cycle word strobe
// - data_oe      out  1   dataout valid, same cycle as clkout
// - dataout      out  18  link word
// - counter      out  6   good words received
// - LED_alert    out  1   sticky CRC-error flag
// BEHAVIOUR
// - Reset values: all outputs 0; both FSMs in IDLE; edge-detect registers 0; both RAM contents don't-care.
// - Message for address a: msg = {a[4:0], 2'b00, a[4:0]}.
// - CRC computation: bit-serial long division, one bit per cycle.
//   - Load R = {msg, 4'b0}.
//   - For i = 15 down to 4: if R[i], R ^= POLY << (i-4). This takes 12 cycles.
//   - crc = R[3:0].
// - TX FSM states: IDLE=0, CRC=1, WRITE=2, NEXT=3, READY=4, SEND=5, OUT=6, WAIT=7.
//   - IDLE: on btn edge, go to CRC. This clears address_tx, address_rx, counter and LED_alert.
//   - CRC: stay 12 cycles, then go to WRITE.
//   - WRITE: wren_tx=1 for 1 cycle; write {1, a==DEPTH-1, msg, crc}.
//   - NEXT: if a==DEPTH-1, go to READY; else a++ and go to CRC. Each word takes 14 cycles.
//   - READY: on btn_SEND edge, set address_tx=0 and go to SEND.
//   - SEND: issue synchronous RAM read (1-cycle latency).
//   - OUT: clkout=1, data_oe=1 for 1 cycle; dataout = q, with bit 4 XOR err_inject.
//   - WAIT: hold until RX returns to IDLE. Then if the word was last, go to IDLE; else a++ and go to SEND.
//   - dataout holds its last value outside OUT.
// - RX FSM states: IDLE=0, CHECK=1, WRITE=2.
//   - IDLE: on clkout, capture dataout and go to CHECK.
//   - CHECK: divide the 16-bit {msg, crc} by POLY over 12 cycles.
//   - WRITE: zero remainder -> write the word at address_rx, then address_rx++ and counter++ (saturate at 63).
//   - WRITE: nonzero remainder -> LED_alert=1 and no write.
//   - After WRITE, return to IDLE.
// - Ignored inputs: btn outside TX IDLE; btn_SEND outside TX READY; a held button gives one edge only.
// - Sending a frame does not regenerate the TX RAM.
//   - btn_SEND in READY after a completed send resends the same frame.
//   - counter and address_rx continue from their current values; address_rx wraps mod 32.
// - A new btn edge in IDLE regenerates the frame and clears all RX status.
// - rst mid-operation: next edge returns both FSMs to IDLE and all outputs to 0.
//   - An in-flight word is dropped; LED_alert clears.
// TESTING
// - rst high 2 cycles -> all outputs 0; state_tx=0; state_rx=0.
// - btn pulse -> first WRITE stores addr0=0x20000 and addr1=0x2081D; addr31=0x3F9F3.
//   - READY reached within 460 cycles of the btn pulse.
// - btn_SEND in READY -> 32 clkout strobes with dataout 0x20000, 0x2081D, ..., 0x3F9F3.
//   - Final state: counter=32, LED_alert=0, TX and RX back in IDLE.
// - Send with err_inject=1 -> LED_alert=1 and counter unchanged.
//   - Flipped word 0x2080D yields a nonzero remainder.
// - Second btn then btn_SEND, no errors -> counter cleared then 32; LED_alert cleared to 0.
// - btn_SEND before generation finishes, or btn during send -> ignored; no state change.

Source files
------------

// File: rtl/ddio_crc_link_top.sv
// CRC-4 link demo: TX generates a frame of CRC-protected words into a RAM, streams it
// over a strobed word link, and RX re-checks each word, storing and counting good ones.
module ddio_crc_link_top #(
  parameter int unsigned MESS_LEN = 12,
  parameter int unsigned CRC_LEN  = 4,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned W        = MESS_LEN + CRC_LEN + 2
) (
  input  logic          board_clk,
  input  logic          rst,
  input  logic          btn,
  input  logic          btn_SEND,
  input  logic          err_inject,
  output logic [2:0]    state_tx,
  output logic [2:0]    state_rx,
  output logic [AW-1:0] address_tx,
  output logic [AW-1:0] address_rx,
  output logic          wren_tx,
  output logic          clkout,
  output logic          data_oe,
  output logic [W-1:0]  dataout,
  output logic [5:0]    counter,
  output logic          LED_alert
);

  localparam int unsigned DW = MESS_LEN + CRC_LEN;
  localparam logic [CRC_LEN:0] POLY = 5'b10011;
  localparam int unsigned STEPS = MESS_LEN - 1;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_CRC = 3'd1, TX_WRITE = 3'd2, TX_NEXT = 3'd3,
    TX_READY = 3'd4, TX_SEND = 3'd5, TX_OUT = 3'd6, TX_WAIT = 3'd7
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_CHECK = 3'd1, RX_WRITE = 3'd2
  } rx_state_t;

  // One long-division step: the top bit is resolved, then shifted out
  function automatic logic [DW-1:0] div_step(input logic [DW-1:0] r);
    logic [DW-1:0] x;
    x = r[DW-1] ? (r ^ {POLY, {(DW-CRC_LEN-1){1'b0}}}) : r;
    return x << 1;
  endfunction

  function automatic logic [MESS_LEN-1:0] msg_of(input logic [AW-1:0] a);
    return {a, 2'b00, a};
  endfunction

  tx_state_t        tx_state;
  rx_state_t        rx_state;
  logic             btn_q, send_q;
  logic [DW-1:0]    tx_r, rx_r;
  logic [3:0]       tx_cnt, rx_cnt;
  logic [W-1:0]     tx_q, rx_word;
  logic [W-1:0]     tx_ram [DEPTH];
  logic [W-1:0]     rx_ram [DEPTH];
  logic             btn_edge, send_edge, gen_start, rx_good;
  logic [W-1:0]     tx_wdata;

  assign btn_edge  = btn & ~btn_q;
  assign send_edge = btn_SEND & ~send_q;
  assign gen_start = (tx_state == TX_IDLE) && btn_edge;
  assign rx_good   = (rx_r[DW-1 -: CRC_LEN] == '0);
  assign tx_wdata  = {1'b1, address_tx == AW'(DEPTH-1), msg_of(address_tx), tx_r[DW-1 -: CRC_LEN]};
  assign state_tx  = tx_state;
  assign state_rx  = rx_state;

  always_ff @(posedge board_clk) begin
    if (wren_tx) tx_ram[address_tx] <= tx_wdata;
    tx_q <= tx_ram[address_tx];
  end

  always_ff @(posedge board_clk) begin
    if (rx_state == RX_WRITE && rx_good && rx_word[W-1]) rx_ram[address_rx] <= rx_word;
  end

  // TX: frame generation, then word-by-word streaming with RX handshake
  always_ff @(posedge board_clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      btn_q      <= 1'b0;
      send_q     <= 1'b0;
      address_tx <= '0;
      tx_r       <= '0;
      tx_cnt     <= '0;
      wren_tx    <= 1'b0;
      clkout     <= 1'b0;
      data_oe    <= 1'b0;
      dataout    <= '0;
    end else begin
      btn_q   <= btn;
      send_q  <= btn_SEND;
      wren_tx <= 1'b0;
      clkout  <= 1'b0;
      data_oe <= 1'b0;
      case (tx_state)
        TX_IDLE: if (btn_edge) begin
          address_tx <= '0;
          tx_r       <= {msg_of('0), {CRC_LEN{1'b0}}};
          tx_cnt     <= '0;
          tx_state   <= TX_CRC;
        end
        TX_CRC: begin
          tx_r   <= div_step(tx_r);
          tx_cnt <= tx_cnt + 4'd1;
          if (tx_cnt == 4'(STEPS)) begin
            wren_tx  <= 1'b1;
            tx_state <= TX_WRITE;
          end
        end
        TX_WRITE: tx_state <= TX_NEXT;
        TX_NEXT: if (address_tx == AW'(DEPTH-1)) begin
          tx_state <= TX_READY;
        end else begin
          address_tx <= address_tx + AW'(1);
          tx_r       <= {msg_of(address_tx + AW'(1)), {CRC_LEN{1'b0}}};
          tx_cnt     <= '0;
          tx_state   <= TX_CRC;
        end
        TX_READY: if (send_edge) begin
          address_tx <= '0;
          tx_state   <= TX_SEND;
        end
        TX_SEND: tx_state <= TX_OUT;
        TX_OUT: begin
          clkout   <= 1'b1;
          data_oe  <= 1'b1;
          dataout  <= tx_q ^ (W'(err_inject) << 4);
          tx_state <= TX_WAIT;
        end
        TX_WAIT: if (!clkout && rx_state == RX_IDLE) begin
          if (dataout[W-2]) begin
            tx_state <= TX_IDLE;
          end else begin
            address_tx <= address_tx + AW'(1);
            tx_state   <= TX_SEND;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX: capture strobed word, re-divide, store and count if remainder is zero
  always_ff @(posedge board_clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_r       <= '0;
      rx_cnt     <= '0;
      rx_word    <= '0;
      address_rx <= '0;
      counter    <= '0;
      LED_alert  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (clkout) begin
          rx_word  <= dataout;
          rx_r     <= dataout[DW-1:0];
          rx_cnt   <= '0;
          rx_state <= RX_CHECK;
        end
        RX_CHECK: begin
          rx_r   <= div_step(rx_r);
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'(STEPS)) rx_state <= RX_WRITE;
        end
        RX_WRITE: begin
          if (rx_good) begin
            address_rx <= address_rx + AW'(1);
            if (counter != 6'd63) counter <= counter + 6'd1;
          end else begin
            LED_alert <= 1'b1;
          end
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
      if (gen_start) begin
        address_rx <= '0;
        counter    <= '0;
        LED_alert  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddio_crc_link_top.sv
// Directed bench for ddio_crc_link_top: scoreboard of expected link words checked per strobe.
module tb_ddio_crc_link_top;

  logic        clk = 1'b0;
  logic        rst, btn, btn_SEND, err_inject;
  logic [2:0]  state_tx, state_rx;
  logic [4:0]  address_tx, address_rx;
  logic        wren_tx, clkout, data_oe;
  logic [17:0] dataout;
  logic [5:0]  counter;
  logic        LED_alert;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  ddio_crc_link_top dut (
    .board_clk(clk), .rst(rst), .btn(btn), .btn_SEND(btn_SEND), .err_inject(err_inject),
    .state_tx(state_tx), .state_rx(state_rx), .address_tx(address_tx), .address_rx(address_rx),
    .wren_tx(wren_tx), .clkout(clkout), .data_oe(data_oe), .dataout(dataout),
    .counter(counter), .LED_alert(LED_alert)
  );

  function automatic logic [3:0] crc4(input logic [11:0] m);
    logic [15:0] r;
    logic [15:0] p;
    r = {m, 4'b0000};
    p = 16'h0013;
    for (int i = 15; i >= 4; i--)
      if (r[i]) r = r ^ (p << (i - 4));
    return r[3:0];
  endfunction

  function automatic logic [17:0] exp_word(input int a, input logic flip);
    logic [4:0]  aa;
    logic [11:0] m;
    logic [17:0] w;
    aa = a[4:0];
    m  = {aa, 2'b00, aa};
    w  = {1'b1, (a == 31), m, crc4(m)};
    if (flip) w[4] = ~w[4];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state_tx"}, 32'(state_tx), 0);
    chk({tag, "_state_rx"}, 32'(state_rx), 0);
    chk({tag, "_address_tx"}, 32'(address_tx), 0);
    chk({tag, "_address_rx"}, 32'(address_rx), 0);
    chk({tag, "_wren_tx"}, 32'(wren_tx), 0);
    chk({tag, "_clkout"}, 32'(clkout), 0);
    chk({tag, "_data_oe"}, 32'(data_oe), 0);
    chk({tag, "_dataout"}, 32'(dataout), 0);
    chk({tag, "_counter"}, 32'(counter), 0);
    chk({tag, "_LED_alert"}, 32'(LED_alert), 0);
  endtask

  // Press btn (held for 'hold' cycles) and follow generation until READY
  task automatic generate_frame(input int hold, input bit early_send);
    int k = 0;
    int strobes = 0;
    btn = 1'b1;
    for (int i = 0; i < 460; i++) begin
      step(1);
      if (i + 1 == hold) btn = 1'b0;
      if (early_send) btn_SEND = (i >= 40 && i < 43);
      if (clkout) strobes++;
      if (wren_tx) begin
        chk("gen_wr_addr", 32'(address_tx), 32'(k));
        k++;
      end
      if (state_tx == 3'd4) break;
    end
    btn = 1'b0;
    btn_SEND = 1'b0;
    chk("gen_ready", 32'(state_tx), 4);
    chk("gen_writes", 32'(k), 32);
    chk("gen_no_strobe", 32'(strobes), 0);
  endtask

  // Press btn_SEND, score each strobed word, optionally poke btn mid-frame
  task automatic send_frame(input logic flip, input bit btn_mid);
    int seen = 0;
    int budget = 2000;
    for (int a = 0; a < 32; a++) exp_q.push_back(exp_word(a, flip));
    err_inject = flip;
    btn_SEND = 1'b1;
    step(1);
    btn_SEND = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      step(1);
      budget--;
      btn = btn_mid && (seen == 5);
      if (clkout) begin
        chk("strobe_data_oe", 32'(data_oe), 1);
        chk("strobe_dataout", 32'(dataout), 32'(exp_q.pop_front()));
        seen++;
      end
    end
    btn = 1'b0;
    chk("send_words_left", 32'(exp_q.size()), 0);
    exp_q.delete();
    budget = 100;
    while (!(state_tx == 3'd0 && state_rx == 3'd0) && budget > 0) begin
      step(1);
      budget--;
    end
    err_inject = 1'b0;
    chk("send_end_tx_idle", 32'(state_tx), 0);
    chk("send_end_rx_idle", 32'(state_rx), 0);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; btn_SEND = 1'b0; err_inject = 1'b0;
    step(2);
    check_all_zero("reset");
    rst = 1'b0;
    step(2);

    // Generation with a premature btn_SEND, then a clean send
    generate_frame(1, 1'b1);
    send_frame(1'b0, 1'b0);
    chk("clean_counter", 32'(counter), 32);
    chk("clean_led", 32'(LED_alert), 0);
    chk("clean_addr_rx", 32'(address_rx), 0);

    // btn_SEND in IDLE is ignored
    btn_SEND = 1'b1;
    step(3);
    btn_SEND = 1'b0;
    step(3);
    chk("idle_send_ignored", 32'(state_tx), 0);

    // Held button regenerates once; then send with corrupted link
    generate_frame(30, 1'b0);
    chk("regen_counter_clr", 32'(counter), 0);
    send_frame(1'b1, 1'b0);
    chk("err_led", 32'(LED_alert), 1);
    chk("err_counter", 32'(counter), 0);

    // Regenerate clears status; btn during send is ignored
    generate_frame(1, 1'b0);
    chk("regen_led_clr", 32'(LED_alert), 0);
    chk("regen_counter", 32'(counter), 0);
    send_frame(1'b0, 1'b1);
    chk("resend_counter", 32'(counter), 32);
    chk("resend_led", 32'(LED_alert), 0);

    // Reset mid-send drops everything
    generate_frame(1, 1'b0);
    btn_SEND = 1'b1;
    step(1);
    btn_SEND = 1'b0;
    step(100);
    rst = 1'b1;
    step(1);
    check_all_zero("midrst");
    rst = 1'b0;
    step(3);
    chk("post_rst_tx", 32'(state_tx), 0);
    chk("post_rst_rx", 32'(state_rx), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
